// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS word-indexed 32-bit registers with
// byte-strobe writes, independent write and read FSMs, OKAY/SLVERR responses.
module axi4_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    wstate_t               r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    rstate_t               r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wr_fire;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic                  w_wr_ok;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_ar_hs;
    logic                  w_rd_ok;
    logic [IDX_W-1:0]      w_rd_idx;

    // A held channel stands in for the live one; the write fires once both are present.
    assign w_aw_hs   = AWVALID & r_awready;
    assign w_w_hs    = WVALID & r_wready;
    assign w_wr_addr = r_aw_held ? r_aw_addr : AWADDR;
    assign w_wr_data = r_w_held ? r_wdata : WDATA;
    assign w_wr_strb = r_w_held ? r_wstrb : WSTRB;
    assign w_wr_fire = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_ok   = (w_wr_addr < ADDR_WIDTH'(NUM_REGS));
    assign w_wr_idx  = w_wr_addr[IDX_W-1:0];

    assign w_ar_hs   = ARVALID & r_arready;
    assign w_rd_ok   = (ARADDR < ADDR_WIDTH'(NUM_REGS));
    assign w_rd_idx  = ARADDR[IDX_W-1:0];

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

    // Register storage: byte-masked update on an in-range write; out-of-range writes are dropped.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_fire && w_wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wr_strb[b]) begin
                    r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write FSM: capture AW and W in either order, respond, then wait for BREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_fire) begin
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_addr <= AWADDR;
                            r_awready <= 1'b0;
                        end else if (!r_aw_held) begin
                            r_awready <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_w_held  <= 1'b1;
                            r_wdata   <= WDATA;
                            r_wstrb   <= WSTRB;
                            r_wready  <= 1'b0;
                        end else if (!r_w_held) begin
                            r_wready  <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read FSM: register data/response on the AR handshake, hold until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_ok ? r_regs[w_rd_idx] : '0;
                        r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
